// File: rtl/div_pkg.sv
// Shared types and constants for the 8-bit divider dispatcher.
package div_pkg;

    localparam int WIDTH = 8;
    localparam logic [WIDTH-1:0] DZ_QUOTIENT = '1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DZ,
        HOLD
    } div_state_e;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

endpackage

// File: rtl/div_op_fifo.sv
// Synchronous operand FIFO; no pass-through, extra pointer bit for full/empty.
module div_op_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_dispatch_8.sv
// Dispatcher for the 8-bit iterative divider: operand FIFO, launch FSM, div-by-zero trap.
// Define DIVU_SIGNED_EN for two's-complement operands with sign fix-up on capture.
module div_dispatch_8
    import div_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             div_start,
    output logic [WIDTH-1:0] div_src1,
    output logic [WIDTH-1:0] div_src2,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    input  logic             div_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_dz
);

    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;
    logic [WIDTH-1:0]   src_a;
    logic [WIDTH-1:0]   src_b;
    logic [WIDTH-1:0]   fix_q;
    logic [WIDTH-1:0]   fix_r;
    logic [WIDTH-1:0]   op_a;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    div_state_e         state;
    div_state_e         state_nxt;

    assign {head_a, head_b} = head;
    assign in_ready  = ~full;
    assign push      = in_valid & ~full;
    assign div_start = (state == ISSUE);
    assign out_valid = (state == HOLD);

    div_op_fifo #(
        .DW   (2 * WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .n_rst(n_rst),
        .push (push),
        .wdata({in_a, in_b}),
        .pop  (pop),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

`ifdef DIVU_SIGNED_EN
    logic sgn_a;
    logic sgn_b;

    assign src_a = head_a[WIDTH-1] ? neg_w(head_a) : head_a;
    assign src_b = head_b[WIDTH-1] ? neg_w(head_b) : head_b;
    assign fix_q = (sgn_a ^ sgn_b) ? neg_w(div_q) : div_q;
    assign fix_r = sgn_a ? neg_w(div_r) : div_r;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sgn_a <= 1'b0;
            sgn_b <= 1'b0;
        end else if (pop) begin
            sgn_a <= head_a[WIDTH-1];
            sgn_b <= head_b[WIDTH-1];
        end
    end
`else
    assign src_a = head_a;
    assign src_b = head_b;
    assign fix_q = div_q;
    assign fix_r = div_r;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = (head_b == '0) ? DZ : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (div_done) begin
                    state_nxt = HOLD;
                end
            end
            DZ:   state_nxt = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Divider operands only change on a real launch; a trapped pair leaves them alone.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_src1 <= '0;
            div_src2 <= '0;
            op_a     <= '0;
            out_q    <= '0;
            out_r    <= '0;
            out_dz   <= 1'b0;
        end else begin
            if (pop) begin
                op_a <= head_a;
                if (head_b != '0) begin
                    div_src1 <= src_a;
                    div_src2 <= src_b;
                end
            end
            if (state == DZ) begin
                out_q  <= DZ_QUOTIENT;
                out_r  <= op_a;
                out_dz <= 1'b1;
            end else if (state == WAIT && div_done) begin
                out_q  <= fix_q;
                out_r  <= fix_r;
                out_dz <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_dispatch_8.sv
// Bench for div_dispatch_8 with a behavioural iterative divider and a result-queue model.
module tb_div_dispatch_8;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       div_start;
    logic [7:0] div_src1;
    logic [7:0] div_src2;
    logic [7:0] div_q;
    logic [7:0] div_r;
    logic       div_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_q;
    logic [7:0] out_r;
    logic       out_dz;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int n_results = 0;

    logic [16:0] exp_q[$];

    int  lat_cfg  = 4;
    bit  lat_rand = 1'b0;
    bit  rnd_ready = 1'b0;
    bit  stalled;

    always #5 clk = ~clk;

    div_dispatch_8 dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .div_start(div_start),
        .div_src1 (div_src1),
        .div_src2 (div_src2),
        .div_q    (div_q),
        .div_r    (div_r),
        .div_done (div_done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_q    (out_q),
        .out_r    (out_r),
        .out_dz   (out_dz)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result model {dz, q, r} straight from the arithmetic definition.
    function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
        int q;
        int r;
        if (b == 8'd0) return {1'b1, 8'hFF, a};
`ifdef DIVU_SIGNED_EN
        q = int'($signed(a)) / int'($signed(b));
        r = int'($signed(a)) % int'($signed(b));
`else
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
`endif
        return {1'b0, q[7:0], r[7:0]};
    endfunction

    // Iterative divider stand-in: never finishes on a zero divisor.
    logic [7:0] d_a;
    logic [7:0] d_b;
    int         d_cnt;
    bit         d_busy;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_busy   <= 1'b0;
            d_cnt    <= 0;
            d_a      <= 8'd0;
            d_b      <= 8'd0;
            div_done <= 1'b0;
            div_q    <= 8'd0;
            div_r    <= 8'd0;
        end else begin
            div_done <= 1'b0;
            if (div_start) begin
                d_a    <= div_src1;
                d_b    <= div_src2;
                d_busy <= 1'b1;
                d_cnt  <= lat_rand ? int'($urandom_range(1, 6)) : lat_cfg;
            end else if (d_busy && d_b != 8'd0) begin
                if (d_cnt <= 1) begin
                    d_busy   <= 1'b0;
                    div_done <= 1'b1;
                    div_q    <= d_a / d_b;
                    div_r    <= d_a % d_b;
                end else begin
                    d_cnt <= d_cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (n_rst) begin
            if (div_start) n_starts++;
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b));
            if (out_valid && out_ready) begin
                n_results++;
                if (exp_q.size() == 0) begin
                    check("spurious_result", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_q", 32'(out_q), 32'(e[15:8]));
                    check("res_r", 32'(out_r), 32'(e[7:0]));
                    check("res_dz", 32'(out_dz), 32'(e[16]));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Call at posedge+1; returns at posedge+1 right after the push edge.
    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            stalled = 1'b1;
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int t = 0;
        while (!out_valid && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 32'(exp_q.size() != 0 || out_valid), 32'd0);
    endtask

    task automatic push_expect(input string tag, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] q,
                               input logic [7:0] r, input logic dz);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        push(a, b);
        wait_valid(100);
        check({tag, "_q"}, 32'(out_q), 32'(q));
        check({tag, "_r"}, 32'(out_r), 32'(r));
        check({tag, "_dz"}, 32'(out_dz), 32'(dz));
        out_ready = 1'b1;
        wait_idle(100);
    endtask

    logic [7:0] tab_a [6] = '{8'd200, 8'd17, 8'd255, 8'd9, 8'd0, 8'd128};
    logic [7:0] tab_b [6] = '{8'd3, 8'd5, 8'd16, 8'd9, 8'd4, 8'd7};

    initial begin
        int s0;
        int r0;
        int stall_idx;
        bit seen;
        logic [7:0] q0;
        logic [7:0] rr0;
        logic [7:0] ra;
        logic [7:0] rb;

        n_rst     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'd0;
        in_b      = 8'd0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_out_q", 32'(out_q), 32'd0);
        check("rst_out_r", 32'(out_r), 32'd0);
        check("rst_out_dz", 32'(out_dz), 32'd0);
        check("rst_src1", 32'(div_src1), 32'd0);
        check("rst_src2", 32'(div_src2), 32'd0);
        @(posedge clk);
        #1 n_rst = 1'b1;

        // 100 / 7: launch one cycle after the head lands, single pulse.
        s0 = n_starts;
        @(posedge clk);
        #1;
        push(8'd100, 8'd7);
        @(negedge clk);
        check("t1_start_early", 32'(div_start), 32'd0);
        @(negedge clk);
        check("t1_start", 32'(div_start), 32'd1);
        check("t1_src1", 32'(div_src1), 32'd100);
        check("t1_src2", 32'(div_src2), 32'd7);
        @(negedge clk);
        check("t1_start_pulse", 32'(div_start), 32'd0);
        wait_valid(100);
        check("t1_q", 32'(out_q), 32'd14);
        check("t1_r", 32'(out_r), 32'd2);
        check("t1_dz", 32'(out_dz), 32'd0);
        out_ready = 1'b1;
        wait_idle(100);
        check("t1_starts", 32'(n_starts - s0), 32'd1);

        // 55 / 0: trapped, result two edges after the push edge.
        s0 = n_starts;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        push(8'd55, 8'd0);
        @(negedge clk);
        check("t2_valid_e1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t2_valid_e2", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t2_valid_e3", 32'(out_valid), 32'd1);
        check("t2_q", 32'(out_q), 32'hFF);
        check("t2_r", 32'(out_r), 32'd55);
        check("t2_dz", 32'(out_dz), 32'd1);
        out_ready = 1'b1;
        wait_idle(100);
        check("t2_no_start", 32'(n_starts - s0), 32'd0);

        // Six back-to-back pairs against a slow divider: 4 queued then stall.
        lat_cfg   = 8;
        out_ready = 1'b1;
        r0        = n_results;
        stall_idx = -1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            stalled = 1'b0;
            push(tab_a[i], tab_b[i]);
            if (stalled && stall_idx < 0) stall_idx = i;
        end
        check("t3_stall_idx", 32'(stall_idx), 32'd5);
        wait_idle(500);
        check("t3_results", 32'(n_results - r0), 32'd6);

        // Hold the result 20 cycles with a second pair waiting.
        lat_cfg   = 3;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        push(8'd9, 8'd2);
        push(8'd50, 8'd6);
        wait_valid(100);
        q0   = out_q;
        rr0  = out_r;
        s0   = n_starts;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_q !== q0 || out_r !== rr0) seen = 1'b1;
        end
        check("t4_stable", 32'(seen), 32'd0);
        check("t4_no_start", 32'(n_starts - s0), 32'd0);
        check("t4_q", 32'(q0), 32'd4);
        check("t4_r", 32'(rr0), 32'd1);
        out_ready = 1'b1;
        wait_idle(200);

        // Reset while the divider is busy.
        lat_cfg   = 30;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        push(8'd200, 8'd1);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (div_start) seen = 1'b1;
        end
        check("t5_launched", 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b0;
        @(negedge clk);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1 n_rst = 1'b1;
        r0   = n_results;
        s0   = n_starts;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t5_no_result", 32'(seen), 32'd0);
        check("t5_no_start", 32'(n_starts - s0), 32'd0);
        check("t5_results", 32'(n_results - r0), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        lat_cfg = 4;

`ifdef DIVU_SIGNED_EN
        push_expect("s_m7_2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0);
        push_expect("s_m128_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0);
        push_expect("s_7_m2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0);
        push_expect("s_dz", 8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1);
`else
        push_expect("u_255_1", 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0);
        push_expect("u_3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0);
`endif

        // Random traffic with random divider latency and consumer stalls.
        lat_rand  = 1'b1;
        rnd_ready = 1'b1;
        r0        = n_results;
        @(posedge clk);
        #1;
        for (int i = 0; i < 80; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            push(ra, rb);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rnd_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_idle(2000);
        check("rand_results", 32'(n_results - r0), 32'd80);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
